// File: rtl/riscv_ex_seq_if.sv
// Execute-sequencer bus: decode/ALU/MDU/writeback signals seen by riscv_ex_seq.
// The slave side is the sequencer; the master side is its surrounding pipeline.
interface riscv_ex_seq_if #(
  parameter int XLEN = 64
);
  logic            id_valid;
  logic [1:0]      id_class;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] alu_r;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_r;
  logic            wb_ready;
  logic            ex_stall;
  logic            csr_commit;
  logic            mdu_start;
  logic            wb_valid;
  logic [XLEN-1:0] wb_r;
  logic [4:0]      wb_rd;
  logic            timeout_err;

  modport master (
    output id_valid, id_class, id_rd, alu_r, mdu_done, mdu_r, wb_ready,
    input  ex_stall, csr_commit, mdu_start, wb_valid, wb_r, wb_rd, timeout_err
  );

  modport slave (
    input  id_valid, id_class, id_rd, alu_r, mdu_done, mdu_r, wb_ready,
    output ex_stall, csr_commit, mdu_start, wb_valid, wb_r, wb_rd, timeout_err
  );
endinterface

// File: rtl/riscv_ex_seq.sv
// Execute-stage sequencer: dispatches ALU/CSR/MDU instructions, waits for the
// multi-cycle MDU with a bounded timeout and presents one writeback result.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | nothing in flight, ready to dispatch
// ALU_WB   | ALU/CSR result on wb_r (pass-through of alu_r), awaiting wb_ready
// MDU_WAIT | MDU launched, counting cycles until mdu_done or timeout
// MDU_WB   | captured MDU result on wb_r, awaiting wb_ready
module riscv_ex_seq #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  riscv_ex_seq_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_CSR = 2'b01;
  localparam logic [1:0] CLS_MDU = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_WB   = 2'd1,
    MDU_WAIT = 2'd2,
    MDU_WB   = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_q;
  logic            tmo_q;

  logic            dispatch;
  logic            stall;
  logic            wb_vld;
  logic [XLEN-1:0] wb_data;

  // Accept a new instruction only when nothing is pending or the ALU result
  // is leaving this cycle; reset masks dispatch so the strobes stay low.
  always_comb begin
    dispatch = !rst && bus.id_valid &&
               ((state == IDLE) || ((state == ALU_WB) && bus.wb_ready));
  end

  // Stall and writeback presentation decoded from the current state.
  always_comb begin
    stall   = 1'b0;
    wb_vld  = 1'b0;
    wb_data = '0;
    case (state)
      ALU_WB: begin
        stall   = !bus.wb_ready;
        wb_vld  = 1'b1;
        wb_data = bus.alu_r;
      end
      MDU_WAIT: begin
        stall = 1'b1;
      end
      MDU_WB: begin
        stall   = 1'b1;
        wb_vld  = 1'b1;
        wb_data = result;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign bus.ex_stall    = stall;
  assign bus.csr_commit  = dispatch && (bus.id_class == CLS_CSR);
  assign bus.mdu_start   = dispatch && (bus.id_class == CLS_MDU);
  assign bus.wb_valid    = wb_vld;
  assign bus.wb_r        = wb_data;
  assign bus.wb_rd       = rd_q;
  assign bus.timeout_err = tmo_q;

  // Sequencer state, MDU wait counter, captured result, rd and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      rd_q   <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (dispatch) begin
        rd_q <= bus.id_rd;
      end
      case (state)
        IDLE, ALU_WB: begin
          if (dispatch) begin
            case (bus.id_class)
              CLS_ALU, CLS_CSR: state <= ALU_WB;
              CLS_MDU: begin
                state <= MDU_WAIT;
                cnt   <= '0;
              end
              default: state <= IDLE;
            endcase
          end else if ((state == ALU_WB) && bus.wb_ready) begin
            state <= IDLE;
          end
        end
        MDU_WAIT: begin
          // completion wins over timeout in the last allowed cycle
          if (bus.mdu_done) begin
            result <= bus.mdu_r;
            state  <= MDU_WB;
          end else if (cnt == CNT_LAST) begin
            tmo_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MDU_WB: begin
          if (bus.wb_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ex_seq.sv
// Self-checking bench for riscv_ex_seq: directed sequences with a writeback
// scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_riscv_ex_seq;

  localparam int          XLEN  = 64;
  localparam int          TMO   = 8;
  localparam logic [63:0] ALU_K = 64'hA5A5_0000_0000_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] id_op = '0;

  riscv_ex_seq_if #(.XLEN(XLEN)) bus ();

  riscv_ex_seq #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk   = 0;
  int n_fail  = 0;
  int wb_seen = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;
  wb_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ALU model: registered result of the operand, frozen while stalled.
  always @(posedge clk) begin
    if (!bus.ex_stall) bus.alu_r <= id_op ^ ALU_K;
  end

  // Writeback monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    wb_t e;
    if (!rst && bus.wb_valid) begin
      wb_seen++;
      if (bus.wb_ready) begin
        chk("sb_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_wb_rd", 64'(bus.wb_rd), 64'(e.rd));
          chk("sb_wb_r", bus.wb_r, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] cls, input logic [4:0] rd, input logic [63:0] op);
    bus.id_valid = 1'b1;
    bus.id_class = cls;
    bus.id_rd    = rd;
    id_op        = op;
    if (cls == 2'b00 || cls == 2'b01) push_exp(rd, op ^ ALU_K);
  endtask

  task automatic idle_in();
    bus.id_valid = 1'b0;
    bus.id_class = 2'b11;
    bus.id_rd    = 5'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_stall"}, 64'(bus.ex_stall), 64'd0);
    chk({tag, "_csr_commit"}, 64'(bus.csr_commit), 64'd0);
    chk({tag, "_mdu_start"}, 64'(bus.mdu_start), 64'd0);
    chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
    chk({tag, "_wb_r"}, bus.wb_r, 64'd0);
    chk({tag, "_wb_rd"}, 64'(bus.wb_rd), 64'd0);
    chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb_before;
    bus.id_valid = 1'b1;
    bus.id_class = 2'b01;
    bus.id_rd    = 5'd31;
    bus.mdu_done = 1'b1;
    bus.mdu_r    = 64'hFFFF;
    bus.wb_ready = 1'b1;

    // reset with hostile inputs
    @(negedge clk);
    chk_all_zero("rst");
    bus.id_class = 2'b10;
    #1;
    chk("rst_mdu_start_cls10", 64'(bus.mdu_start), 64'd0);
    cyc();
    rst = 1'b0;
    idle_in();
    bus.mdu_done = 1'b0;
    bus.mdu_r    = '0;
    cyc();

    // back-to-back ALU
    for (int i = 0; i < 5; i++) begin
      if (i < 3) issue(2'b00, 5'(i + 1), 64'(64'h100 + i));
      else idle_in();
      @(negedge clk);
      chk("b2b_ex_stall", 64'(bus.ex_stall), 64'd0);
      chk("b2b_wb_valid", 64'(bus.wb_valid), 64'((i >= 1) && (i <= 3)));
      if (i >= 1 && i <= 3) chk("b2b_wb_rd", 64'(bus.wb_rd), 64'(i));
      cyc();
    end

    // CSR
    issue(2'b01, 5'd5, 64'h55);
    @(negedge clk);
    chk("csr_commit_on", 64'(bus.csr_commit), 64'd1);
    chk("csr_mdu_start", 64'(bus.mdu_start), 64'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk("csr_commit_off", 64'(bus.csr_commit), 64'd0);
    chk("csr_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("csr_wb_rd", 64'(bus.wb_rd), 64'd5);
    cyc();

    // MDU with completion after 5 wait cycles
    issue(2'b10, 5'd7, 64'h0);
    @(negedge clk);
    chk("mdu_start_on", 64'(bus.mdu_start), 64'd1);
    chk("mdu_disp_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    idle_in();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("mdu_wait_stall", 64'(bus.ex_stall), 64'd1);
      chk("mdu_wait_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("mdu_start_off", 64'(bus.mdu_start), 64'd0);
      cyc();
    end
    bus.mdu_done = 1'b1;
    bus.mdu_r    = 64'h1234;
    push_exp(5'd7, 64'h1234);
    @(negedge clk);
    chk("mdu_done_stall", 64'(bus.ex_stall), 64'd1);
    chk("mdu_done_wb_valid", 64'(bus.wb_valid), 64'd0);
    cyc();
    bus.mdu_r    = 64'hDEAD;
    bus.wb_ready = 1'b0;
    @(negedge clk);
    chk("mdu_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("mdu_wb_r", bus.wb_r, 64'h1234);
    chk("mdu_wb_rd", 64'(bus.wb_rd), 64'd7);
    chk("mdu_wb_stall", 64'(bus.ex_stall), 64'd1);
    cyc();
    bus.mdu_done = 1'b0;
    bus.wb_ready = 1'b1;
    bus.id_valid = 1'b1;
    bus.id_class = 2'b01;
    bus.id_rd    = 5'd8;
    @(negedge clk);
    chk("mdu_wb_r_hold", bus.wb_r, 64'h1234);
    chk("mdu_wb_no_dispatch", 64'(bus.csr_commit), 64'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk("mdu_after_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mdu_after_stall", 64'(bus.ex_stall), 64'd0);
    cyc();

    // backpressure in ALU_WB, next CSR held until wb_ready
    issue(2'b00, 5'd9, 64'hA0A0);
    @(negedge clk);
    cyc();
    bus.wb_ready = 1'b0;
    bus.mdu_done = 1'b1;
    issue(2'b01, 5'd10, 64'hB0B0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_stall", 64'(bus.ex_stall), 64'd1);
      chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("bp_wb_rd", 64'(bus.wb_rd), 64'd9);
      chk("bp_wb_r", bus.wb_r, 64'hA0A0 ^ ALU_K);
      chk("bp_csr_held", 64'(bus.csr_commit), 64'd0);
      cyc();
    end
    bus.mdu_done = 1'b0;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_stall", 64'(bus.ex_stall), 64'd0);
    chk("bp_release_csr", 64'(bus.csr_commit), 64'd1);
    cyc();
    idle_in();
    @(negedge clk);
    chk("bp_next_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("bp_next_wb_rd", 64'(bus.wb_rd), 64'd10);
    cyc();

    // class 11 from IDLE and from ALU_WB
    issue(2'b11, 5'd11, 64'h0);
    @(negedge clk);
    chk("none_csr", 64'(bus.csr_commit), 64'd0);
    chk("none_mdu", 64'(bus.mdu_start), 64'd0);
    cyc();
    issue(2'b00, 5'd12, 64'hC0);
    @(negedge clk);
    chk("none_idle_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("none_idle_stall", 64'(bus.ex_stall), 64'd0);
    cyc();
    issue(2'b11, 5'd13, 64'h0);
    @(negedge clk);
    chk("none_alu_wb_rd", 64'(bus.wb_rd), 64'd12);
    cyc();
    idle_in();
    @(negedge clk);
    chk("none_alu_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("none_rd_latched", 64'(bus.wb_rd), 64'd13);
    cyc();

    // timeout, mdu_done never asserted
    wb_before = wb_seen;
    issue(2'b10, 5'd14, 64'h0);
    @(negedge clk);
    chk("tmo_mdu_start", 64'(bus.mdu_start), 64'd1);
    cyc();
    idle_in();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk("tmo_wait_err", 64'(bus.timeout_err), 64'd0);
      chk("tmo_wait_stall", 64'(bus.ex_stall), 64'd1);
      cyc();
    end
    @(negedge clk);
    chk("tmo_err_set", 64'(bus.timeout_err), 64'd1);
    chk("tmo_idle_stall", 64'(bus.ex_stall), 64'd0);
    chk("tmo_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("tmo_no_wb_pulse", 64'(wb_seen), 64'(wb_before));
    cyc();
    cyc();
    @(negedge clk);
    chk("tmo_err_sticky", 64'(bus.timeout_err), 64'd1);
    cyc();

    // reset during MDU_WAIT
    issue(2'b10, 5'd15, 64'h0);
    cyc();
    idle_in();
    cyc();
    cyc();
    rst          = 1'b1;
    bus.id_valid = 1'b1;
    bus.id_class = 2'b01;
    bus.mdu_done = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    cyc();
    rst          = 1'b0;
    bus.mdu_done = 1'b0;
    issue(2'b00, 5'd16, 64'hD0D0);
    @(negedge clk);
    chk("post_rst_stall", 64'(bus.ex_stall), 64'd0);
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk("post_rst_wb_valid1", 64'(bus.wb_valid), 64'd1);
    chk("post_rst_wb_rd", 64'(bus.wb_rd), 64'd16);
    cyc();

    // completion in the last allowed wait cycle beats timeout
    issue(2'b10, 5'd17, 64'h0);
    cyc();
    idle_in();
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      chk("last_wait_stall", 64'(bus.ex_stall), 64'd1);
      cyc();
    end
    bus.mdu_done = 1'b1;
    bus.mdu_r    = 64'hCAFE_F00D_0000_0077;
    push_exp(5'd17, 64'hCAFE_F00D_0000_0077);
    @(negedge clk);
    chk("last_done_wb_valid", 64'(bus.wb_valid), 64'd0);
    cyc();
    bus.mdu_done = 1'b0;
    @(negedge clk);
    chk("last_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("last_wb_r", bus.wb_r, 64'hCAFE_F00D_0000_0077);
    chk("last_timeout_err", 64'(bus.timeout_err), 64'd0);
    cyc();
    @(negedge clk);
    chk("last_idle_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("last_err_clear", 64'(bus.timeout_err), 64'd0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
